// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter:
//   - arb_state_e : burst sequencer state encoding
//   - len_width() : width of a beat-count field able to hold BURST_MAX
//   - idx_width() : width of a requester index
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_GAP     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    // One extra bit so BURST_MAX itself is representable even when it is a
    // power of two.
    function automatic int len_width(input int burst_max);
        return $clog2(burst_max) + 1;
    endfunction

    function automatic int idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_rr_pick
// Combinational round-robin search: returns the first asserted request found
// starting at (last_i + 1) mod NREQ and wrapping upward.
// Ports:
//   req_i   [NREQ]  request levels
//   last_i  [IDX_W] index granted most recently
//   valid_o         any request present
//   idx_o   [IDX_W] selected requester (0 when valid_o is low)
// -----------------------------------------------------------------------------
module mem_bus_arbiter_rr_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every signal written in an always_comb block gets a default before
    // any conditional assignment, otherwise a latch is inferred.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        cand    = '0;
        // Walk from the farthest candidate to the nearest so that the nearest
        // asserted request after last_i is the one left standing.
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_i) + k) % NREQ);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule : mem_bus_arbiter_rr_pick

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one word-wide memory port between NREQ requesters. Arbitration is
// round-robin and only happens in IDLE; the winner keeps the grant for a whole
// incrementing-address burst of 1..BURST_MAX beats.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req_i/req_we_i                 per-requester request level and direction
//   req_addr_i/req_len_i           packed start address / beat count
//   req_wdata_i                    packed write data for the current beat
//   gnt_o                          one-hot grant, held across the burst
//   beat_done_o/beat_last_o        per-beat completion pulse / final beat flag
//   rdata_o                        read data, valid with beat_done_o
//   busy_o                         sequencer not in IDLE
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory access request
//   mem_ack_i/mem_rdata_i          memory completion and read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int ADDR_W    = 16,
    parameter  int DATA_W    = 32,
    parameter  int BURST_MAX = 8,
    localparam int LEN_W     = len_width(BURST_MAX),
    localparam int IDX_W     = idx_width(NREQ)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          req_we_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*LEN_W-1:0]    req_len_i,
    input  logic [NREQ*DATA_W-1:0]   req_wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic                     beat_done_o,
    output logic                     beat_last_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     busy_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic [DATA_W-1:0]        mem_rdata_i
);

    // Unpacked views of the packed per-requester buses.
    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [LEN_W-1:0]  len_arr   [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
        assign len_arr[i]   = req_len_i[i*LEN_W +: LEN_W];
        assign wdata_arr[i] = req_wdata_i[i*DATA_W +: DATA_W];
    end

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              beat_done_q, beat_done_d;
    logic              beat_last_q, beat_last_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [LEN_W-1:0]  pick_len;

    mem_bus_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pick_len = len_arr[pick_idx];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        beat_done_d = 1'b0;
        beat_last_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d           = pick_idx;
                    we_d            = req_we_i[pick_idx];
                    addr_d          = addr_arr[pick_idx];
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = ST_ACCESS;
                    // A zero length still moves one beat; oversize lengths clip.
                    if (pick_len == '0) begin
                        count_d = LEN_W'(1);
                    end else if (pick_len > LEN_W'(BURST_MAX)) begin
                        count_d = LEN_W'(BURST_MAX);
                    end else begin
                        count_d = pick_len;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_ack_i) begin
                    rdata_d     = mem_rdata_i;
                    beat_done_d = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    count_d     = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        beat_last_d = 1'b1;
                        gnt_d       = '0;
                        state_d     = ST_RELEASE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end

            // One dead cycle lets the owner present the next beat's write data
            // in response to beat_done.
            ST_GAP: begin
                state_d = ST_ACCESS;
            end

            ST_RELEASE: begin
                last_d  = sel_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            last_q      <= IDX_W'(NREQ - 1);
            we_q        <= 1'b0;
            addr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            beat_done_q <= 1'b0;
            beat_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            beat_done_q <= beat_done_d;
            beat_last_q <= beat_last_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign beat_done_o = beat_done_q;
    assign beat_last_o = beat_last_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign mem_req_o   = (state_q == ST_ACCESS);
    assign mem_we_o    = (state_q == ST_ACCESS) && we_q;
    assign mem_addr_o  = addr_q;
    // Live mux: the owner may change its write data between beats.
    assign mem_wdata_o = wdata_arr[sel_q];

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. Expected beats are pushed onto a
// scoreboard when requests are issued and popped when the memory model
// acknowledges an access; beat completion is checked on the following cycle.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 8;
    localparam int LEN_W     = 4;

    typedef struct {
        int                idx;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_we;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ*LEN_W-1:0]   req_len;
    logic [NREQ*DATA_W-1:0]  req_wdata;
    logic [NREQ-1:0]         gnt;
    logic                    beat_done;
    logic                    beat_last;
    logic [DATA_W-1:0]       rdata;
    logic                    busy;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_ack;
    logic [DATA_W-1:0]       mem_rdata;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t sb[$];
    beat_t pend;
    bit    pend_v = 1'b0;
    int    ack_delay = 0;
    int    wait_cnt = 0;
    int    remaining [NREQ];
    logic [ADDR_W-1:0] nxt_addr [NREQ];
    logic [ADDR_W-1:0] m_addr [NREQ];
    int    m_len [NREQ];
    logic  m_we [NREQ];
    int    exp_last = NREQ - 1;
    logic [NREQ-1:0] prev_gnt = '0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NREQ      (NREQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .beat_done_o (beat_done),
        .beat_last_o (beat_last),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
    );

    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    function automatic logic [DATA_W-1:0] wfn(input int i, input logic [ADDR_W-1:0] a);
        return {4'hC, 4'(i), 8'h3B, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Combined monitor, requester model and memory model, all on the falling
    // edge so DUT outputs are stable.
    always @(negedge clk) begin
        check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        check("mem_req_without_gnt", 64'(mem_req && (gnt == '0)), 64'd0);

        check("beat_done", 64'(beat_done), 64'(pend_v));
        if (pend_v && beat_done) begin
            check("beat_last", 64'(beat_last), 64'(pend.last));
            check("rdata", 64'(rdata), 64'(pend.rdata));
            nxt_addr[pend.idx] = pend.addr + 16'd1;
            req_wdata[pend.idx*DATA_W +: DATA_W] = wfn(pend.idx, nxt_addr[pend.idx]);
        end
        pend_v = 1'b0;

        // Each requester drops its request once a grant starts; the burst
        // must still complete.
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && !prev_gnt[i]) begin
                if (remaining[i] > 0) remaining[i]--;
                if (remaining[i] == 0) req[i] = 1'b0;
            end
        end
        prev_gnt = gnt;

        if (mem_req && !mem_ack) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
                if (sb.size() == 0) begin
                    check("sb_nonempty_at_ack", 64'd0, 64'd1);
                end else begin
                    pend   = sb.pop_front();
                    pend_v = 1'b1;
                    check("mem_addr", 64'(mem_addr), 64'(pend.addr));
                    check("mem_we", 64'(mem_we), 64'(pend.we));
                    check("gnt_owner", 64'(gnt), 64'(4'b0001 << pend.idx));
                    if (pend.we) check("mem_wdata", 64'(mem_wdata), 64'(pend.wdata));
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            wait_cnt  = 0;
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    task automatic start_burst(input int idx, input logic we, input logic [ADDR_W-1:0] a,
                               input int len, input int nbursts);
        req_we[idx] = we;
        req_addr[idx*ADDR_W +: ADDR_W] = a;
        req_len[idx*LEN_W +: LEN_W] = LEN_W'(len);
        req_wdata[idx*DATA_W +: DATA_W] = wfn(idx, a);
        nxt_addr[idx] = a;
        m_addr[idx] = a;
        m_len[idx] = len;
        m_we[idx] = we;
        remaining[idx] = nbursts;
        req[idx] = 1'b1;
    endtask

    // Reference round-robin over all pending bursts, pushing every beat.
    task automatic predict();
        int rem [NREQ];
        int pick;
        int beats;
        logic [ADDR_W-1:0] a;
        beat_t e;
        for (int i = 0; i < NREQ; i++) rem[i] = remaining[i];
        while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int j = (exp_last + k) % NREQ;
                if (pick < 0 && rem[j] > 0) pick = j;
            end
            beats = (m_len[pick] == 0) ? 1 : ((m_len[pick] > BURST_MAX) ? BURST_MAX : m_len[pick]);
            a = m_addr[pick];
            for (int b = 0; b < beats; b++) begin
                e.idx   = pick;
                e.addr  = a;
                e.we    = m_we[pick];
                e.wdata = wfn(pick, a);
                e.rdata = mem_fn(a);
                e.last  = (b == beats - 1);
                sb.push_back(e);
                a = a + 16'd1;
            end
            rem[pick]--;
            exp_last = pick;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || pend_v || busy || req != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_for(input string tag, input bit want_done, input int budget);
        int n = 0;
        while (!(want_done ? beat_done : mem_req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 0; nxt_addr[i] = '0; m_addr[i] = '0; m_len[i] = 0; m_we[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Simultaneous requesters 0 and 2 straight out of reset.
        ack_delay = 0;
        start_burst(0, 1'b0, 16'h0100, 2, 1);
        start_burst(2, 1'b0, 16'h0200, 2, 1);
        predict();
        @(negedge clk);
        check("simul_first_gnt", 64'(gnt), 64'h1);
        drain("simul_drain", 100);

        // Single read from requester 1 with exact cycle timing.
        start_burst(1, 1'b0, 16'h0040, 1, 1);
        predict();
        @(negedge clk);
        check("single_gnt_t1", 64'(gnt), 64'h2);
        check("single_mem_req_t1", 64'(mem_req), 64'd1);
        @(negedge clk);
        check("single_done_t2", 64'(beat_done), 64'd1);
        check("single_last_t2", 64'(beat_last), 64'd1);
        check("single_rdata_t2", 64'(rdata), 64'(mem_fn(16'h0040)));
        check("single_busy_t2", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        check("single_busy_t4", 64'(busy), 64'd0);
        drain("single_drain", 50);

        // Wrapping write burst with a slow memory.
        ack_delay = 2;
        start_burst(0, 1'b1, 16'hFFFE, 4, 1);
        predict();
        @(negedge clk);
        check("write_mem_we", 64'(mem_we), 64'd1);
        drain("write_drain", 200);
        check("write_wrapped_addr", 64'(mem_addr), 64'h0002);

        // Oversize length saturates; request drops mid-burst.
        ack_delay = 1;
        start_burst(2, 1'b0, 16'h3000, 15, 1);
        predict();
        drain("len15_drain", 300);

        // Zero length means one beat.
        start_burst(3, 1'b1, 16'h4000, 0, 1);
        predict();
        drain("len0_drain", 100);
        check("len0_addr_after", 64'(mem_addr), 64'h4001);

        // Fairness: all four held for two bursts each.
        ack_delay = 0;
        for (int i = 0; i < NREQ; i++) start_burst(i, 1'b0, 16'(16'h5000 + 16'(i) * 16'h10), 1, 2);
        predict();
        drain("fair_drain", 300);

        // Reset during beat 2 of a 5-beat burst.
        ack_delay = 3;
        start_burst(2, 1'b0, 16'h1230, 5, 1);
        predict();
        wait_for("rst_wait_beat1", 1'b1, 100);
        @(negedge clk);
        wait_for("rst_wait_access2", 1'b0, 100);
        reset = 1'b1;
        sb.delete();
        exp_last = NREQ - 1;
        @(negedge clk);
        check("midrst_gnt", 64'(gnt), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        check("midrst_mem_we", 64'(mem_we), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr), 64'd0);
        check("midrst_rdata", 64'(rdata), 64'd0);
        check("midrst_beat_last", 64'(beat_last), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        ack_delay = 1;
        start_burst(3, 1'b0, 16'h0777, 2, 1);
        predict();
        @(negedge clk);
        check("post_rst_gnt", 64'(gnt), 64'h8);
        check("post_rst_addr", 64'(mem_addr), 64'h0777);
        drain("post_rst_drain", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_bus_arbiter
